// File: rtl/rv_pkg.sv
// rv_pkg: RV32I-subset encodings, ALU ops and decoded-instruction
// types shared by the decode/execute back end.
package rv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT,
    ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_LUI
  } alu_op_e;

  typedef enum logic [5:0] {
    CL_NONE = 6'b000000,
    CL_R    = 6'b000001,
    CL_I    = 6'b000010,
    CL_S    = 6'b000100,
    CL_B    = 6'b001000,
    CL_U    = 6'b010000,
    CL_J    = 6'b100000
  } iclass_e;

  typedef struct packed {
    logic    legal;
    iclass_e iclass;
    alu_op_e alu_op;
    logic    use_imm;
    logic    rd_we;
    logic    is_load;
    logic    is_store;
    logic    is_branch;
    logic    is_jal;
    logic    is_jalr;
    logic    is_auipc;
  } dec_t;

  function automatic logic [31:0] imm_gen(
    input logic [31:0] i,
    input iclass_e     c
  );
    logic [31:0] r;
    case (c)
      CL_I:    r = {{20{i[31]}}, i[31:20]};
      CL_S:    r = {{20{i[31]}}, i[31:25], i[11:7]};
      CL_B:    r = {{19{i[31]}}, i[31], i[7],
                    i[30:25], i[11:8], 1'b0};
      CL_U:    r = {i[31:12], 12'b0};
      CL_J:    r = {{11{i[31]}}, i[31], i[19:12],
                    i[20], i[30:21], 1'b0};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic alu_op_e alu_from_f3(
    input logic [2:0] f3,
    input logic       alt
  );
    alu_op_e r;
    case (f3)
      F3_ADD:  r = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  r = ALU_SLL;
      F3_SLT:  r = ALU_SLT;
      F3_SLTU: r = ALU_SLTU;
      F3_XOR:  r = ALU_XOR;
      F3_SR:   r = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_1rw.sv
// dmem_1rw: single-port synchronous word RAM, registered read,
// write-first when reading and writing the same cycle.
module dmem_1rw #(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/rv_decode_execute.sv
// rv_decode_execute: decode, execute and data-memory back end.
// Define RV_DECODE_EXECUTE_FWD_EN to bypass execute results to operands.
module rv_decode_execute
  import rv_pkg::*;
#(
  parameter int DMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instruction,
  input  logic [9:0]  pc,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        rd_we,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        branch,
  output logic [9:0]  target,
  output logic        illegal
);

  localparam int AW = $clog2(DMEM_DEPTH);

  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [9:0]  dec_pc;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd;
  dec_t        d;
  logic        vld;
  logic [31:0] imm;

  logic        fwd_a;
  logic        fwd_b;
  logic [31:0] a_val;
  logic [31:0] b_val;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_y;
  logic [31:0] link;
  logic [31:0] wb;
  logic        br_cond;
  logic        take;
  logic [9:0]  tgt;

  logic [31:0] ex_result;
  logic        ex_load;
  logic [31:0] ram_rdata;

  // Decode register; a taken redirect squashes the wrong-path fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_valid <= 1'b0;
      dec_instr <= '0;
      dec_pc    <= '0;
    end else begin
      dec_valid <= instr_valid & ~take;
      dec_instr <= instruction;
      dec_pc    <= pc;
    end
  end

  assign opc      = dec_instr[6:0];
  assign rd       = dec_instr[11:7];
  assign f3       = dec_instr[14:12];
  assign rs1_addr = dec_instr[19:15];
  assign rs2_addr = dec_instr[24:20];
  assign f7       = dec_instr[31:25];

  always_comb begin
    d = '0;
    unique case (1'b1)
      opc == OPC_OP: begin
        d.iclass = CL_R;
        d.legal  = (f7 == F7_BASE) ||
                   (f7 == F7_ALT &&
                    (f3 == F3_ADD || f3 == F3_SR));
        d.alu_op = alu_from_f3(f3, f7[5]);
        d.rd_we  = 1'b1;
      end
      opc == OPC_OPIMM: begin
        d.iclass  = CL_I;
        d.use_imm = 1'b1;
        if (f3 == F3_SLL)
          d.legal = f7 == F7_BASE;
        else if (f3 == F3_SR)
          d.legal = f7 == F7_BASE || f7 == F7_ALT;
        else
          d.legal = 1'b1;
        d.alu_op = alu_from_f3(f3, f3 == F3_SR && f7[5]);
        d.rd_we  = 1'b1;
      end
      opc == OPC_LOAD: begin
        d.iclass  = CL_I;
        d.use_imm = 1'b1;
        d.legal   = f3 == F3_W;
        d.is_load = 1'b1;
        d.rd_we   = 1'b1;
      end
      opc == OPC_STORE: begin
        d.iclass   = CL_S;
        d.use_imm  = 1'b1;
        d.legal    = f3 == F3_W;
        d.is_store = 1'b1;
      end
      opc == OPC_BRANCH: begin
        d.iclass    = CL_B;
        d.legal     = f3 != 3'b010 && f3 != 3'b011;
        d.is_branch = 1'b1;
      end
      opc == OPC_JAL: begin
        d.iclass = CL_J;
        d.legal  = 1'b1;
        d.is_jal = 1'b1;
        d.rd_we  = 1'b1;
      end
      opc == OPC_JALR: begin
        d.iclass  = CL_I;
        d.use_imm = 1'b1;
        d.legal   = f3 == 3'b000;
        d.is_jalr = 1'b1;
        d.rd_we   = 1'b1;
      end
      opc == OPC_LUI: begin
        d.iclass  = CL_U;
        d.use_imm = 1'b1;
        d.legal   = 1'b1;
        d.alu_op  = ALU_LUI;
        d.rd_we   = 1'b1;
      end
      opc == OPC_AUIPC: begin
        d.iclass   = CL_U;
        d.use_imm  = 1'b1;
        d.legal    = 1'b1;
        d.is_auipc = 1'b1;
        d.rd_we    = 1'b1;
      end
      default: ;
    endcase
    d.rd_we = d.rd_we & d.legal & (rd != 5'd0);
  end

  assign vld = dec_valid & d.legal;
  assign imm = imm_gen(dec_instr, d.iclass);

`ifdef RV_DECODE_EXECUTE_FWD_EN
  assign fwd_a = rd_we && (rd_addr == rs1_addr);
  assign fwd_b = rd_we && (rd_addr == rs2_addr);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  assign a_val = (rs1_addr == 5'd0) ? '0 :
                 fwd_a ? rd_data : rs1_data;
  assign b_val = (rs2_addr == 5'd0) ? '0 :
                 fwd_b ? rd_data : rs2_data;

  assign op_a = d.is_auipc ? {20'b0, dec_pc, 2'b00} : a_val;
  assign op_b = d.use_imm ? imm : b_val;

  always_comb begin
    alu_y = '0;
    unique case (d.alu_op)
      ALU_ADD:  alu_y = op_a + op_b;
      ALU_SUB:  alu_y = op_a - op_b;
      ALU_SLL:  alu_y = op_a << op_b[4:0];
      ALU_SLT:  alu_y = {31'b0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_y = {31'b0, op_a < op_b};
      ALU_XOR:  alu_y = op_a ^ op_b;
      ALU_SRL:  alu_y = op_a >> op_b[4:0];
      ALU_SRA:  alu_y = $signed(op_a) >>> op_b[4:0];
      ALU_OR:   alu_y = op_a | op_b;
      ALU_AND:  alu_y = op_a & op_b;
      ALU_LUI:  alu_y = op_b;
      default:  alu_y = '0;
    endcase
  end

  always_comb begin
    br_cond = 1'b0;
    case (f3)
      F3_BEQ:  br_cond = a_val == b_val;
      F3_BNE:  br_cond = a_val != b_val;
      F3_BLT:  br_cond = $signed(a_val) < $signed(b_val);
      F3_BGE:  br_cond = $signed(a_val) >= $signed(b_val);
      F3_BLTU: br_cond = a_val < b_val;
      F3_BGEU: br_cond = a_val >= b_val;
      default: br_cond = 1'b0;
    endcase
  end

  assign take = vld & (d.is_jal | d.is_jalr |
                       (d.is_branch & br_cond));
  // JALR reuses the ALU adder for rs1+imm.
  assign tgt  = d.is_jalr ? alu_y[11:2] : dec_pc + imm[11:2];
  assign link = {20'b0, dec_pc + 10'd1, 2'b00};
  assign wb   = (d.is_jal | d.is_jalr) ? link : alu_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_we     <= 1'b0;
      rd_addr   <= '0;
      ex_result <= '0;
      ex_load   <= 1'b0;
      branch    <= 1'b0;
      target    <= '0;
      illegal   <= 1'b0;
    end else begin
      rd_we     <= vld & d.rd_we;
      rd_addr   <= rd;
      ex_result <= wb;
      ex_load   <= vld & d.is_load;
      branch    <= take;
      target    <= tgt;
      illegal   <= dec_valid & ~d.legal;
    end
  end

  dmem_1rw #(
    .DEPTH (DMEM_DEPTH)
  ) u_dmem (
    .clk   (clk),
    .en    (vld & (d.is_load | d.is_store)),
    .we    (vld & d.is_store),
    .addr  (alu_y[AW+1:2]),
    .wdata (b_val),
    .rdata (ram_rdata)
  );

  assign rd_data = ex_load ? ram_rdata : ex_result;

endmodule

// File: tb/tb_rv_decode_execute.sv
// tb_rv_decode_execute: table-driven program with a scoreboard queue,
// plus asynchronous-reset sequences; register file modelled here.
module tb_rv_decode_execute;

  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] LD  = 7'b0000011;

  typedef struct {
    int          id;
    logic        vld;
    logic [31:0] ins;
    logic [9:0]  pc;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        br;
    logic [9:0]  tgt;
    logic        ill;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [9:0]  pc;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        rd_we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        branch;
  logic [9:0]  target;
  logic        illegal;

  logic [31:0] rf [32] = '{default: '0};

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vt [$];
  vec_t sb [$];

  always #5 clk = ~clk;

  rv_decode_execute dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instruction (instruction),
    .pc          (pc),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .rd_we       (rd_we),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .branch      (branch),
    .target      (target),
    .illegal     (illegal)
  );

  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];

  always @(posedge clk)
    if (rd_we) rf[rd_addr] <= rd_data;

  function automatic logic [31:0] e_r(
    input logic [6:0] f7, input logic [4:0] rs2,
    input logic [4:0] rs1, input logic [2:0] f3,
    input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] e_i(
    input int imm, input logic [4:0] rs1,
    input logic [2:0] f3, input logic [4:0] rd,
    input logic [6:0] opc);
    logic [11:0] v;
    v = 12'(imm);
    return {v, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] e_s(
    input int imm, input logic [4:0] rs2,
    input logic [4:0] rs1);
    logic [11:0] v;
    v = 12'(imm);
    return {v[11:5], rs2, rs1, 3'b010, v[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] e_b(
    input int imm, input logic [4:0] rs2,
    input logic [4:0] rs1, input logic [2:0] f3);
    logic [12:0] v;
    v = 13'(imm);
    return {v[12], v[10:5], rs2, rs1, f3,
            v[4:1], v[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] e_j(
    input int imm, input logic [4:0] rd);
    logic [20:0] v;
    v = 21'(imm);
    return {v[20], v[10:1], v[11], v[19:12], rd, 7'b1101111};
  endfunction

  function automatic vec_t mk(
    input logic [31:0] ins, input int p,
    input logic we, input logic [4:0] rd,
    input logic [31:0] data, input logic br,
    input int tgt, input logic ill);
    vec_t v;
    v.id   = vt.size();
    v.vld  = 1'b1;
    v.ins  = ins;
    v.pc   = 10'(p);
    v.we   = we;
    v.rd   = rd;
    v.data = data;
    v.br   = br;
    v.tgt  = 10'(tgt);
    v.ill  = ill;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic compare(input vec_t v);
    string t;
    t = $sformatf("v%0d", v.id);
    chk({t, ".rd_we"}, 32'(rd_we), 32'(v.we));
    if (v.we) begin
      chk({t, ".rd_addr"}, 32'(rd_addr), 32'(v.rd));
      chk({t, ".rd_data"}, rd_data, v.data);
    end
    chk({t, ".branch"}, 32'(branch), 32'(v.br));
    if (v.br)
      chk({t, ".target"}, 32'(target), 32'(v.tgt));
    chk({t, ".illegal"}, 32'(illegal), 32'(v.ill));
  endtask

  task automatic step(input vec_t v);
    instr_valid = v.vld;
    instruction = v.ins;
    pc          = v.pc;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 2) compare(sb.pop_front());
    @(negedge clk);
  endtask

  task automatic rst_pulse_check(input string nm);
    rst_n = 1'b0;
    #1;
    chk({nm, ".rd_we"},   32'(rd_we),   32'd0);
    chk({nm, ".branch"},  32'(branch),  32'd0);
    chk({nm, ".target"},  32'(target),  32'd0);
    chk({nm, ".rd_addr"}, 32'(rd_addr), 32'd0);
    chk({nm, ".rd_data"}, rd_data,      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t bub;
    rst_n       = 1'b1;
    instr_valid = 1'b0;
    instruction = '0;
    pc          = '0;
    #1 rst_n = 1'b0;

    vt.push_back(mk(e_i(5, 0, 0, 1, OPI), 0, 1, 1, 32'd5, 0, 0, 0));
    vt.push_back(mk(e_i(-3, 0, 0, 2, OPI), 1, 1, 2, 32'hFFFFFFFD, 0, 0, 0));
    vt.push_back(mk(e_i(0, 0, 0, 0, OPI), 2, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(e_r(7'h00, 2, 1, 0, 3), 3, 1, 3, 32'd2, 0, 0, 0));
    vt.push_back(mk(e_r(7'h20, 2, 1, 0, 4), 4, 1, 4, 32'd8, 0, 0, 0));
    vt.push_back(mk(e_r(7'h00, 2, 1, 2, 5), 5, 1, 5, 32'd0, 0, 0, 0));
    vt.push_back(mk(e_r(7'h00, 2, 1, 3, 6), 6, 1, 6, 32'd1, 0, 0, 0));
    vt.push_back(mk(e_i(32'h401, 2, 5, 7, OPI), 7, 1, 7, 32'hFFFFFFFE, 0, 0, 0));
    vt.push_back(mk(e_r(7'h00, 2, 1, 7, 18), 8, 1, 18, 32'd5, 0, 0, 0));
    vt.push_back(mk(e_r(7'h00, 2, 1, 6, 19), 9, 1, 19, 32'hFFFFFFFD, 0, 0, 0));
    vt.push_back(mk(e_i(31, 1, 1, 24, OPI), 10, 1, 24, 32'h80000000, 0, 0, 0));
    vt.push_back(mk(e_i(28, 2, 5, 25, OPI), 11, 1, 25, 32'h0000000F, 0, 0, 0));
    vt.push_back(mk(e_s(8, 1, 0), 12, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(e_i(8, 0, 2, 8, LD), 13, 1, 8, 32'd5, 0, 0, 0));
    vt.push_back(mk(e_i(32'h408, 0, 2, 9, LD), 14, 1, 9, 32'd5, 0, 0, 0));
    vt.push_back(mk(e_b(16, 1, 1, 0), 10, 0, 0, 0, 1, 14, 0));
    vt.push_back(mk(e_i(1, 0, 0, 10, OPI), 11, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(e_j(-8, 11), 20, 1, 11, 32'd84, 1, 18, 0));
    vt.push_back(mk(e_i(1, 0, 0, 10, OPI), 21, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(e_i(0, 0, 0, 0, OPI), 18, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(e_i(4, 11, 0, 0, 7'b1100111), 19, 0, 0, 0, 1, 22, 0));
    vt.push_back(mk(e_i(1, 0, 0, 10, OPI), 20, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(32'h0000007F, 22, 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(e_r(7'h01, 2, 1, 0, 26), 23, 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(e_i(-1, 0, 0, 12, OPI), 24, 1, 12, 32'hFFFFFFFF, 0, 0, 0));
    vt.push_back(mk({20'hABCDE, 5'd13, 7'b0110111}, 25, 1, 13, 32'hABCDE000, 0, 0, 0));
    vt.push_back(mk({20'h00001, 5'd14, 7'b0010111}, 3, 1, 14, 32'h0000100C, 0, 0, 0));
    vt.push_back(mk(e_r(7'h00, 1, 1, 0, 0), 27, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(e_b(8, 1, 1, 1), 30, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(e_i(7, 0, 0, 15, OPI), 31, 1, 15, 32'd7, 0, 0, 0));
    bub = mk(e_i(1, 0, 0, 10, OPI), 32, 0, 0, 0, 0, 0, 0);
    bub.vld = 1'b0;
    vt.push_back(bub);
`ifdef RV_DECODE_EXECUTE_FWD_EN
    vt.push_back(mk(e_i(9, 0, 0, 20, OPI), 40, 1, 20, 32'd9, 0, 0, 0));
    vt.push_back(mk(e_r(7'h00, 20, 20, 0, 21), 41, 1, 21, 32'd18, 0, 0, 0));
    vt.push_back(mk(e_i(8, 0, 2, 22, LD), 42, 1, 22, 32'd5, 0, 0, 0));
    vt.push_back(mk(e_r(7'h00, 1, 22, 0, 23), 43, 1, 23, 32'd10, 0, 0, 0));
`endif

    #11;
    chk("rst.rd_we",   32'(rd_we),   32'd0);
    chk("rst.branch",  32'(branch),  32'd0);
    chk("rst.illegal", 32'(illegal), 32'd0);
    chk("rst.rd_addr", 32'(rd_addr), 32'd0);
    chk("rst.target",  32'(target),  32'd0);
    chk("rst.rd_data", rd_data,      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vt[i]) step(vt[i]);
    bub.id = 999;
    step(bub);
    step(bub);
    sb.delete();

    // Write-back in flight when reset is asserted.
    instr_valid = 1'b1;
    instruction = e_i(3, 0, 0, 16, OPI);
    pc          = 10'd40;
    @(negedge clk);
    instr_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("mid.pre_we", 32'(rd_we), 32'd1);
    rst_pulse_check("mid_wb");

    // Branch pulse in flight when reset is asserted.
    instr_valid = 1'b1;
    instruction = e_b(16, 1, 1, 0);
    pc          = 10'd10;
    @(negedge clk);
    instr_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("mid.pre_br",  32'(branch), 32'd1);
    chk("mid.pre_tgt", 32'(target), 32'd14);
    rst_pulse_check("mid_br");
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
